// File: rtl/sub_arb_pkg.sv
// Shared defaults and helpers for the shared-subtractor arbiter.
// Holds width defaults, the ID width helper and the response field layout.
package sub_arb_pkg;

  localparam int unsigned DefNumReq      = 4;
  localparam int unsigned DefInDataWidth = 8;

  // ID width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Response layout is {borrow_out, difference}: borrow sits just above the difference.
  function automatic int unsigned rsp_borrow_idx(input int unsigned in_width);
    return in_width;
  endfunction

endpackage

// File: rtl/n_bit_subtractor.sv
// Unsigned ripple-borrow subtractor: diff = in1 - in2 - cin, bout set on underflow.
module n_bit_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      diff[i]  = in1[i] ^ in2[i] ^ br[i];
      br[i+1]  = (~in1[i] & in2[i]) | (~in1[i] & br[i]) | (in2[i] & br[i]);
    end
  end

  assign bout = br[N];

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant search starting at rr_ptr, wrapping at NUM_REQ-1.
// grant is one-hot and gated by en; grant_idx/grant_valid are not.
module rr_grant #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);

  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
      cand = (cand == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    if (en && grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing one subtractor among NUM_REQ requesters.
// Result and requester ID are held in a single-entry output register with backpressure.
module sub_share_arbiter
  import sub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned IN_DATAWIDTH  = DefInDataWidth,
  parameter int unsigned OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int unsigned ID_WIDTH      = id_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in1,
  input  logic [NUM_REQ*IN_DATAWIDTH-1:0] req_in2,
  input  logic [NUM_REQ-1:0]              req_cin,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic [OUT_DATAWIDTH-1:0]        rsp_data
);

  localparam int unsigned BorrowIdx = rsp_borrow_idx(IN_DATAWIDTH);

  logic                     rsp_valid_q;
  logic [ID_WIDTH-1:0]      rsp_id_q;
  logic [OUT_DATAWIDTH-1:0] rsp_data_q;
  logic [ID_WIDTH-1:0]      rr_ptr_q;

  logic                     accept;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_WIDTH-1:0]      grant_idx;
  logic                     grant_valid;
  logic                     fire;
  logic [IN_DATAWIDTH-1:0]  sel_in1;
  logic [IN_DATAWIDTH-1:0]  sel_in2;
  logic                     sel_cin;
  logic [IN_DATAWIDTH-1:0]  diff;
  logic                     bout;
  logic [OUT_DATAWIDTH-1:0] rsp_data_d;
  logic [ID_WIDTH-1:0]      rr_ptr_d;

  // Slot is free or draining this cycle.
  assign accept = ~rsp_valid_q | rsp_ready;
  assign fire   = accept & grant_valid;

  // rst_n gates en so req_ready is forced low while reset is held.
  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .en          (accept & rst_n),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  assign sel_in1 = req_in1[32'(grant_idx) * IN_DATAWIDTH +: IN_DATAWIDTH];
  assign sel_in2 = req_in2[32'(grant_idx) * IN_DATAWIDTH +: IN_DATAWIDTH];
  assign sel_cin = req_cin[grant_idx];

  n_bit_subtractor #(
    .N (IN_DATAWIDTH)
  ) u_sub (
    .in1  (sel_in1),
    .in2  (sel_in2),
    .cin  (sel_cin),
    .diff (diff),
    .bout (bout)
  );

  always_comb begin
    rsp_data_d                     = '0;
    rsp_data_d[IN_DATAWIDTH-1:0]   = diff;
    rsp_data_d[BorrowIdx]          = bout;
  end

  assign rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (fire) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= grant_idx;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end else if (accept) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Scoreboard bench for sub_share_arbiter: directed scenarios followed by random traffic.
module tb_sub_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int OW = W + 1;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_in1;
  logic [NR*W-1:0]   req_in2;
  logic [NR-1:0]     req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [OW-1:0]     rsp_data;

  always #5 clk = ~clk;

  sub_share_arbiter #(
    .NUM_REQ       (NR),
    .IN_DATAWIDTH  (W),
    .OUT_DATAWIDTH (OW),
    .ID_WIDTH      (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [OW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  // Requester-side state and reference model state.
  logic [NR-1:0] pend;
  logic [W-1:0]  op1 [NR];
  logic [W-1:0]  op2 [NR];
  logic [NR-1:0] cinr;
  int            m_ptr;
  bit            m_full;
  int            last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
    int d;
    logic [OW-1:0] r;
    d = int'(a) - int'(b) - int'(c);
    r = '0;
    r[W-1:0] = W'((d + (1 << W)) % (1 << W));
    r[W] = (d < 0);
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_in1[i*W +: W] = op1[i];
      req_in2[i*W +: W] = op2[i];
    end
    req_valid = pend;
    req_cin   = cinr;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    pend[i] = 1'b1;
    op1[i]  = a;
    op2[i]  = b;
    cinr[i] = c;
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input logic [NR-1:0] new_req, input bit rdy);
    bit            acc;
    int            g;
    int            idx;
    logic [NR-1:0] exp_rr;
    for (int i = 0; i < NR; i++) begin
      if (new_req[i] && !pend[i]) begin
        set_op(i, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    drive();
    rsp_ready = rdy;
    #1;
    acc = !m_full || rdy;
    g   = -1;
    if (acc) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    if (g >= 0) exp_q.push_back({IW'(g), ref_sub(op1[g], op2[g], cinr[g])});
    @(posedge clk);
    #1;
    if (g >= 0) begin
      pend[g] = 1'b0;
      m_ptr   = (g + 1) % NR;
      m_full  = 1'b1;
    end else if (acc) begin
      m_full = 1'b0;
    end
    last_g = g;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend  = '0;
    model_clear();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle a result is presented it must match the queue head;
  // it is retired only when the consumer takes it, which also checks stall stability.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected no response",
                 rsp_id, rsp_data);
      end else begin
        if ({rsp_id, rsp_data} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL rsp: got id=%0d data=0x%0h expected id=%0d data=0x%0h",
                   rsp_id, rsp_data, exp_q[0].id, exp_q[0].data);
        end
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    pend      = '0;
    cinr      = '0;
    for (int i = 0; i < NR; i++) begin
      op1[i] = '0;
      op2[i] = '0;
    end
    drive();
    do_reset();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);

    // Single request from requester 2.
    set_op(2, 8'h50, 8'h20, 1'b0);
    step('0, 1'b1);
    chk("single_id", 32'(rsp_id), 32'd2);
    chk("single_data", 32'(rsp_data), 32'h030);

    // Borrow case.
    set_op(0, 8'h00, 8'h01, 1'b1);
    step('0, 1'b1);
    chk("borrow_data", 32'(rsp_data), 32'h1FE);
    step('0, 1'b1);

    // All four held valid: 0,1,2,3,0 with no bubbles.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 5; n++) begin
      if (n == 4) set_op(0, 8'h11, 8'h22, 1'b0);
      step('0, 1'b1);
      chk("rr_order", 32'(last_g), 32'(n % NR));
      chk("rr_no_bubble", 32'(rsp_valid), 32'd1);
    end
    step('0, 1'b1);

    // Backpressure: held result, stalled requester accepted on release.
    do_reset();
    set_op(0, 8'h9A, 8'h1B, 1'b0);
    step('0, 1'b1);
    set_op(1, 8'h05, 8'h07, 1'b1);
    repeat (3) step('0, 1'b0);
    chk("stall_id", 32'(rsp_id), 32'd0);
    chk("stall_data", 32'(rsp_data), 32'h07F);
    step('0, 1'b1);
    chk("release_grant", 32'(last_g), 32'd1);
    step('0, 1'b1);

    // Wrap and skip: pointer at 3, requesters 1 and 3.
    do_reset();
    set_op(2, 8'h01, 8'h01, 1'b0);
    step('0, 1'b1);
    set_op(1, 8'h40, 8'h41, 1'b0);
    set_op(3, 8'hFF, 8'h00, 1'b1);
    step('0, 1'b1);
    chk("wrap_first", 32'(last_g), 32'd3);
    step('0, 1'b1);
    chk("wrap_second", 32'(last_g), 32'd1);
    chk("wrap_ptr", 32'(m_ptr), 32'd2);
    step('0, 1'b1);

    // Asynchronous reset mid-cycle while a result is held.
    set_op(2, 8'h33, 8'h11, 1'b0);
    step('0, 1'b0);
    set_op(1, 8'h10, 8'h08, 1'b0);
    set_op(3, 8'h20, 8'h30, 1'b0);
    drive();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rsp_data", 32'(rsp_data), 32'd0);
    chk("async_rsp_id", 32'(rsp_id), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step('0, 1'b1);
    chk("post_reset_grant", 32'(last_g), 32'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(NR'($urandom), $urandom_range(0, 3) != 0);
    end

    repeat (NR + 2) step('0, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sub_share_arbiter.md
# sub_share_arbiter

Round-robin arbiter sharing one `n_bit_subtractor` datapath among NUM_REQ requesters, such as FIR tap-difference or symmetric-tap pre-subtract units. Each request carries two operands and a borrow-in. The granted request is subtracted combinationally. The result is registered with the requester's ID in a single-entry output stage that supports backpressure. Throughput is one result per cycle; latency is one cycle.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters, ≥2
- IN_DATAWIDTH, 8, operand width
- OUT_DATAWIDTH, IN_DATAWIDTH+1, result width: {borrow_out, difference}
- ID_WIDTH, $clog2(NUM_REQ), requester ID width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  request pending, bit i = requester i
- req_ready  output  NUM_REQ  one-hot grant/accept; all zero when no accept
- req_in1  input  NUM_REQ*IN_DATAWIDTH  minuends; requester i at [i*IN_DATAWIDTH +: IN_DATAWIDTH]
- req_in2  input  NUM_REQ*IN_DATAWIDTH  subtrahends, same packing
- req_cin  input  NUM_REQ  borrow-in per requester
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_WIDTH  index of the requester that produced rsp_data
- rsp_data  output  OUT_DATAWIDTH  {borrow_out, in1 − in2 − cin mod 2^IN_DATAWIDTH}

## Operation
- accept = ~rsp_valid | rsp_ready. The output slot is free or draining this cycle.
- Grant search starts at rr_ptr and proceeds upward with wrap at NUM_REQ−1 → 0. It picks the first requester with req_valid set.
- req_ready[g] = accept & grant[g]. The signal is combinational from req_valid and rsp_valid/rsp_ready.
- Requester rule: after req_valid rises, it holds req_valid and its operands stable until req_ready; req_valid must not depend on req_ready.
- Handshake on requester g (req_valid[g] & req_ready[g] at the edge):
  - rsp_data <= subtractor output for g's operands
  - rsp_id <= g
  - rsp_valid <= 1
  - rr_ptr <= (g == NUM_REQ−1) ? 0 : g+1
- accept with no req_valid: rsp_valid <= 0; rsp_data and rsp_id hold; rr_ptr holds.
- No accept (rsp_valid & ~rsp_ready): all registers hold and req_ready is all zero. rsp_data and rsp_id are stable while stalled.
- Arithmetic is unsigned borrow-chain subtraction:
  - difference = (in1 − in2 − cin) mod 2^IN_DATAWIDTH
  - borrow_out = 1 iff in1 < in2 + cin
- Fairness: a continuously asserted requester is granted within NUM_REQ accepted cycles.
- The block has no FSM beyond the rsp_valid flag (EMPTY/FULL) and rr_ptr.

## Timing
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0. req_ready=0 is forced while in reset.
- Reset deassertion mid-stream: an in-flight result is discarded. The first grant after reset goes to the lowest-index valid requester.
- Latency: a handshake at edge N gives rsp_valid=1 with its data after edge N.
- Simultaneous drain and refill (rsp_valid & rsp_ready & a req_valid set): the new result replaces the old at the same edge with no bubble.
- Pointer wrap: a grant to NUM_REQ−1 sets rr_ptr to 0.

## Structure
- Shared package sub_arb_pkg holds:
  - default widths
  - an ID_WIDTH helper function (clog2)
  - the response field layout constant (borrow bit index = IN_DATAWIDTH)
- Sub-module rr_grant (NUM_REQ) takes req_valid, rr_ptr and en, and produces a one-hot grant plus the encoded grant index.
- The top level holds:
  - the operand mux driven by the grant index
  - one n_bit_subtractor instance
  - the output register and rr_ptr

## Test plan
- Reset then a single request: requester 2 sends in1=0x50, in2=0x20, cin=0. Next cycle rsp_valid=1, rsp_id=2, rsp_data=0x030.
- Borrow case: in1=0x00, in2=0x01, cin=1 gives rsp_data=0x1FE (borrow=1, difference=0xFE).
- All 4 requesters held valid with rsp_ready=1: grants are 0,1,2,3,0 on consecutive cycles, one result per cycle with no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with a result held. rsp_data and rsp_id stay stable, req_ready=0; on release the pending requester is accepted the same cycle.
- Wrap and skip: rr_ptr=3 with only requesters 1 and 3 valid gives 3 then 1; rr_ptr ends at 2.
- Asynchronous reset asserted mid-cycle while rsp_valid=1: outputs clear immediately without a clock edge. After release, requesters 1 and 3 valid give a first grant to 1.
